muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide execution unit for the single-issue CPU core. It sits between the register file read ports and the register file write port. It takes rs1/rs2 operands read from the register file, computes one of the eight M-extension operations over a fixed 32-iteration sequence, and issues a one-cycle write of the result back to the register file. The decode/issue logic stalls on `o_busy`.

## Interface
Parameters:
- none; data width fixed at 32, register address width fixed at 5.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  core clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `i_valid`  in  1  start request; sampled only when `o_busy`=0
- `i_funct3`  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- `i_rs1_data`  in  32  operand A (multiplicand / dividend)
- `i_rs2_data`  in  32  operand B (multiplier / divisor)
- `i_rd_addr`  in  5  destination register
- `o_busy`  out  1  high while an operation is in flight
- `o_wr_addr`  out  5  destination for write port; drives register file `i_wr_addr`
- `o_wr_data`  out  32  result; drives register file `i_wr_data`
- `o_wr_en`  out  1  one-cycle write strobe; drives register file `i_wr_en`

## Operation
- FSM states: IDLE, CALC, DONE. `o_busy` = (state != IDLE).
- IDLE: on `i_valid`=1, latch funct3, rd, and operand magnitudes plus sign flags. Clear the iteration counter and go to CALC.
- Signedness:
  - rs1 is signed for MUL, MULH, MULHSU, DIV, REM.
  - rs2 is signed for MUL, MULH, DIV, REM.
  - MUL result is sign-independent.
- CALC, multiply: unsigned shift-add on magnitudes, one multiplier bit per cycle, into a 64-bit product.
- CALC, divide: restoring division on magnitudes, one quotient bit per cycle, 33-bit partial remainder.
- CALC lasts exactly 32 cycles. The 5-bit counter runs 0..31 and wraps to 0 on exit to DONE.
- Sign fix on DONE entry:
  - Product is negated if sign(A) xor sign(B), with signedness applied per funct3.
  - Quotient is negated if sign(A) xor sign(B).
  - Remainder takes the sign of the dividend.
- Result selection:
  - MUL = product[31:0].
  - MULH/MULHSU/MULHU = product[63:32].
  - DIV/DIVU = quotient.
  - REM/REMU = remainder.
- Special cases are overridden at DONE entry; latency is unchanged:
  - Divisor 0: DIV/DIVU = 0xFFFFFFFF, REM/REMU = dividend.
  - DIV 0x80000000 / 0xFFFFFFFF = 0x80000000; REM of the same = 0.
- DONE: `o_wr_en`=1 for exactly one cycle with registered `o_wr_addr`/`o_wr_data`, then go to IDLE.
- rd = 0: the operation and strobe still occur with `o_wr_addr`=0; the register file discards the write.
- `i_valid` while `o_busy`=1: ignored, with no queuing. Upstream must hold the instruction until `o_busy`=0.
- Operands are latched at accept. Input changes afterwards have no effect.

## Timing
- Reset (asynchronous, on `rst_n` low): state IDLE, `o_busy`=0, `o_wr_en`=0, `o_wr_data`=0, `o_wr_addr`=0, counter 0, datapath registers 0.
- Accept edge E0 (IDLE, `i_valid`=1): `o_busy`=1 after E0.
- Edges E1..E32 perform iterations 0..31. State becomes DONE after E32.
- At E33, `o_wr_en`=1 with valid data, visible after E33.
- At E34, `o_wr_en`=0, `o_busy`=0, state IDLE.
- Write latency from accept is 33 cycles. The earliest next accept is E35; throughput is one operation per 35 cycles.
- `o_wr_addr`/`o_wr_data` hold their values after the strobe until the next DONE.
- `rst_n` asserted mid-CALC or in DONE: operation aborted, no write strobe, and all outputs at reset values immediately.
- `rst_n` deasserted with `i_valid`=1: accept occurs on the first rising edge after release.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), rd=5 -> single `o_wr_en` pulse 33 cycles after accept, addr 5, data 0xFFFFFFEB. `o_busy` high for 34 cycles.
- MULH 0x80000000 × 0x80000000 -> 0x40000000. MULHSU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC. REMU same operands -> 1.
- Divisor 0 with A=0x1234: DIV -> 0xFFFFFFFF, REMU -> 0x1234. DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same -> 0. Latency is still 33 cycles in every case.
- Back-to-back: pulse `i_valid` with new operands during CALC -> ignored, exactly one write. Hold `i_valid` -> second accept at E35, second write at E35+33.
- Pull `rst_n` low at iteration 20 -> `o_busy`/`o_wr_en`/`o_wr_data` go to 0 asynchronously. No write occurs, and after release a new MUL completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 shift-add or restoring-divide steps, result strobed 33 cycles after accept.
// No queuing: i_valid is ignored while o_busy is high, so upstream holds the instruction until o_busy drops.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_valid,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  input  logic [4:0]  i_rd_addr,
  output logic        o_busy,
  output logic [4:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_wr_en
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] rem_q, rem_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;

  logic        sgn_a, sgn_b, in_neg_a, in_neg_b;
  logic [31:0] in_mag_a, in_mag_b;
  logic [32:0] mul_sum;
  logic [33:0] div_r, div_trial;
  logic        div_ge, div_zero, div_ovf;
  logic [63:0] prod;
  logic [31:0] quo, rem, dividend, result;

  // Operand conditioning and one datapath step for each algorithm.
  always_comb begin
    sgn_a    = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
    sgn_b    = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
    in_neg_a = sgn_a & i_rs1_data[31];
    in_neg_b = sgn_b & i_rs2_data[31];
    in_mag_a = in_neg_a ? -i_rs1_data : i_rs1_data;
    in_mag_b = in_neg_b ? -i_rs2_data : i_rs2_data;

    // Multiply: low half of acc holds the multiplier and shifts out one bit per step.
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
    // Divide: low half of acc shifts the dividend out and the quotient in.
    div_r     = {rem_q, acc_q[31]};
    div_trial = div_r - {2'b00, b_q};
    div_ge    = ~div_trial[33];

    prod     = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
    quo      = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
    rem      = neg_a_q ? -rem_q[31:0] : rem_q[31:0];
    dividend = neg_a_q ? -a_q : a_q;
    div_zero = (b_q == 32'd0);
    div_ovf  = ~f3_q[0] & neg_a_q & neg_b_q & (a_q == 32'h8000_0000) & (b_q == 32'd1);

    result = 32'd0;
    if (!f3_q[2]) begin
      result = (f3_q[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
    end else if (!f3_q[1]) begin
      result = div_zero ? 32'hFFFF_FFFF : (div_ovf ? 32'h8000_0000 : quo);
    end else begin
      result = div_zero ? dividend : (div_ovf ? 32'd0 : rem);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    rd_d      = rd_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          state_d = CALC;
          cnt_d   = 5'd0;
          f3_d    = i_funct3;
          rd_d    = i_rd_addr;
          a_d     = in_mag_a;
          b_d     = in_mag_b;
          neg_a_d = in_neg_a;
          neg_b_d = in_neg_b;
          acc_d   = {32'd0, (i_funct3[2] ? in_mag_a : in_mag_b)};
          rem_d   = 33'd0;
        end
      end
      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (f3_q[2]) begin
          acc_d[31:0] = {acc_q[30:0], div_ge};
          rem_d       = div_ge ? div_trial[32:0] : div_r[32:0];
        end else begin
          acc_d = {mul_sum, acc_q[31:1]};
        end
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the strobe; the second returns to IDLE.
        if (!wr_en_q) begin
          wr_en_d   = 1'b1;
          wr_addr_d = rd_q;
          wr_data_d = result;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      f3_q      <= 3'd0;
      rd_q      <= 5'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      acc_q     <= 64'd0;
      rem_q     <= 33'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      rd_q      <= rd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign o_busy    = (state_q != IDLE);
  assign o_wr_en   = wr_en_q;
  assign o_wr_addr = wr_addr_q;
  assign o_wr_data = wr_data_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model, and timing/reset corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_rs1_data = 32'd0;
  logic [31:0] i_rs2_data = 32'd0;
  logic [4:0]  i_rd_addr = 5'd0;
  logic        o_busy;
  logic [4:0]  o_wr_addr;
  logic [31:0] o_wr_data;
  logic        o_wr_en;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid   (i_valid),
    .i_funct3  (i_funct3),
    .i_rs1_data(i_rs1_data),
    .i_rs2_data(i_rs2_data),
    .i_rd_addr (i_rd_addr),
    .o_busy    (o_busy),
    .o_wr_addr (o_wr_addr),
    .o_wr_data (o_wr_data),
    .o_wr_en   (o_wr_en)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  // RV32M semantics straight from wide integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one op and watch 36 edges past the accept edge.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int glitch_at,
                        output logic [31:0] data, output logic [4:0] addr,
                        output int lat, output int pulses, output int busy_cyc);
    @(negedge clk);
    i_funct3   = f3;
    i_rs1_data = a;
    i_rs2_data = b;
    i_rd_addr  = rd;
    i_valid    = 1'b1;
    rst_n      = 1'b1;
    @(posedge clk);
    #1;
    i_valid  = 1'b0;
    busy_cyc = int'(o_busy);
    lat      = -1;
    pulses   = 0;
    data     = 32'd0;
    addr     = 5'd0;
    for (int k = 1; k <= 36; k++) begin
      if (k == glitch_at) begin
        i_valid    = 1'b1;
        i_funct3   = 3'd5;
        i_rs1_data = $urandom;
        i_rs2_data = $urandom;
        i_rd_addr  = 5'd31;
      end else begin
        i_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      busy_cyc += int'(o_busy);
      if (o_wr_en) begin
        pulses++;
        if (lat < 0) begin
          lat  = k;
          data = o_wr_data;
          addr = o_wr_addr;
        end
      end
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] exp, input int glitch_at);
    logic [31:0] data;
    logic [4:0]  addr;
    int lat, pulses, busy_cyc;
    run_op(f3, a, b, rd, glitch_at, data, addr, lat, pulses, busy_cyc);
    check($sformatf("%s data", name), data, exp);
    check($sformatf("%s addr", name), {27'd0, addr}, {27'd0, rd});
    check($sformatf("%s latency", name), lat, 32'd33);
    check($sformatf("%s pulses", name), pulses, 32'd1);
    check($sformatf("%s busy_cycles", name), busy_cyc, 32'd34);
  endtask

  initial begin
    vec_t tbl[15];
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;
    int first, second, np;

    tbl[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB};
    tbl[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000};
    tbl[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFF};
    tbl[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFE};
    tbl[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         5'd4,  32'hFFFF_FFFD};
    tbl[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         5'd6,  32'hFFFF_FFFF};
    tbl[6]  = '{3'd5, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'h7FFF_FFFC};
    tbl[7]  = '{3'd7, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'd1};
    tbl[8]  = '{3'd4, 32'h0000_1234,  32'd0,         5'd9,  32'hFFFF_FFFF};
    tbl[9]  = '{3'd7, 32'h0000_1234,  32'd0,         5'd10, 32'h0000_1234};
    tbl[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 5'd11, 32'h8000_0000};
    tbl[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'd0};
    tbl[12] = '{3'd6, 32'h0000_1234,  32'd0,         5'd0,  32'h0000_1234};
    tbl[13] = '{3'd5, 32'h0000_1234,  32'd0,         5'd13, 32'hFFFF_FFFF};
    tbl[14] = '{3'd6, 32'hFFFF_FFF9,  32'd0,         5'd14, 32'hFFFF_FFF9};

    repeat (3) @(posedge clk);
    #1;
    check("reset busy",    {31'd0, o_busy},  32'd0);
    check("reset wr_en",   {31'd0, o_wr_en}, 32'd0);
    check("reset wr_data", o_wr_data,         32'd0);
    check("reset wr_addr", {27'd0, o_wr_addr}, 32'd0);

    for (int i = 0; i < 15; i++)
      do_op($sformatf("vec%0d", i), tbl[i].f3, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].exp, 0);

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = 32'd0;
        default: rb = -32'($urandom_range(1, 9));
      endcase
      if (i == 5) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      rrd = 5'($urandom_range(0, 31));
      do_op($sformatf("rand%0d f3=%0d a=%08h b=%08h", i, rf3, ra, rb), rf3, ra, rb, rrd, ref_model(rf3, ra, rb), 0);
    end

    // New request pulsed mid-CALC must be dropped without disturbing the op in flight.
    do_op("glitch", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd9, 32'hFFFF_FFEB, 10);

    // Held i_valid: second accept at E35, writes at E33 and E68.
    @(negedge clk);
    i_funct3   = 3'd3;
    i_rs1_data = 32'hFFFF_FFFF;
    i_rs2_data = 32'd3;
    i_rd_addr  = 5'd7;
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    first = -1; second = -1; np = 0;
    for (int k = 1; k <= 75; k++) begin
      if (k == 36) i_valid = 1'b0;
      @(posedge clk);
      #1;
      if (k == 34) check("hold busy E34", {31'd0, o_busy}, 32'd0);
      if (k == 35) check("hold busy E35", {31'd0, o_busy}, 32'd1);
      if (o_wr_en) begin
        np++;
        if (first < 0) first = k; else if (second < 0) second = k;
        check("hold data", o_wr_data, 32'd2);
      end
    end
    check("hold first write", first, 32'd33);
    check("hold second write", second, 32'd68);
    check("hold write count", np, 32'd2);

    // Reset during CALC aborts asynchronously; release with i_valid high accepts at once.
    @(negedge clk);
    i_funct3   = 3'd0;
    i_rs1_data = 32'h0000_1234;
    i_rs2_data = 32'h10;
    i_rd_addr  = 5'd4;
    i_valid    = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort busy",    {31'd0, o_busy},  32'd0);
    check("abort wr_en",   {31'd0, o_wr_en}, 32'd0);
    check("abort wr_data", o_wr_data,         32'd0);
    np = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      np += int'(o_wr_en);
    end
    check("abort no write", np, 32'd0);
    do_op("post-reset mul", 3'd0, 32'h0000_1234, 32'h10, 5'd3, 32'h0001_2340, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
